pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16: number of memory-wait cycles before the timeout flag is raised.
REQ-003 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_mem_hazard, input, 1 bit: load-use hazard reported by the ID stage.
REQ-006 SHALL have port i_branch_taken, input, 1 bit: EX-stage branch or jump resolved taken.
REQ-007 SHALL have port i_dmem_req, input, 1 bit: the ME stage is issuing a load or store this cycle.
REQ-008 SHALL have port i_dmem_ack, input, 1 bit: the data memory has completed the current access.
REQ-009 SHALL have ports o_if_stall, o_id_stall, o_ex_stall, o_me_stall, outputs, 1 bit each: per-stage hold.
REQ-010 SHALL have ports o_id_clr, o_ex_clr, outputs, 1 bit each: synchronous clear (bubble) of the IF/ID and ID/EX registers.
REQ-011 SHALL have port o_pc_redirect, output, 1 bit: IF loads the branch target.
REQ-012 SHALL have port o_mem_timeout, output, 1 bit: sticky flag, memory wait exceeded MEM_TIMEOUT.
REQ-013 SHALL have port o_lu_err, output, 1 bit: sticky flag, load-use hazard persisted for more than one cycle.
REQ-014 SHALL have ports o_stall_cnt and o_flush_cnt, outputs, CNT_W bits each: saturating performance counters.

Function
REQ-015 SHALL implement a two-state FSM with states S_RUN and S_MEM_WAIT; all control outputs SHALL be combinational from the state and the inputs.
REQ-016 In S_RUN, the first matching condition SHALL apply (priority: memory wait > branch > load-use):
- i_dmem_req=1 and i_dmem_ack=0: all four stall outputs =1, no clears; next state S_MEM_WAIT.
- i_branch_taken=1: o_pc_redirect=1, o_id_clr=1, o_ex_clr=1, no stalls; o_flush_cnt increments.
- i_mem_hazard=1: o_if_stall=1, o_id_stall=1, o_ex_clr=1, o_me_stall=0, o_ex_stall=0; this inserts exactly one bubble.
- Otherwise: all control outputs =0.
REQ-017 In S_MEM_WAIT, all four stall outputs SHALL equal ~i_dmem_ack; on i_dmem_ack=1 the next state SHALL be S_RUN.
REQ-018 In S_MEM_WAIT, i_branch_taken and i_mem_hazard SHALL be ignored; EX and ID hold their state, so these inputs are re-evaluated in S_RUN.
REQ-019 A request acknowledged in the same cycle (i_dmem_req=1, i_dmem_ack=1) SHALL cause zero stall cycles and leave the FSM in S_RUN.
REQ-020 A wait counter SHALL clear on entry to S_MEM_WAIT and increment each cycle in S_MEM_WAIT.
REQ-021 When the wait counter reaches MEM_TIMEOUT, o_mem_timeout SHALL set; the FSM keeps waiting for i_dmem_ack.
REQ-022 A one-bit register SHALL record an i_mem_hazard stall in the previous cycle.
REQ-023 If i_mem_hazard=1 in S_RUN and the REQ-022 register is set, o_lu_err SHALL set; the bubble is still inserted.
REQ-024 o_stall_cnt SHALL increment by 1 in every cycle in which any stall output =1.
REQ-025 o_stall_cnt and o_flush_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-026 Latency: every control output SHALL respond in the same cycle as its cause; the FSM and counters update on the next edge.

Reset
REQ-027 With clr=1 at a clock edge, the state SHALL become S_RUN and the wait counter, the REQ-022 register, o_mem_timeout, o_lu_err, o_stall_cnt and o_flush_cnt SHALL become 0.
REQ-028 While clr=1, all stall, clear and redirect outputs SHALL be 0, regardless of the other inputs.
REQ-029 clr asserted in S_MEM_WAIT SHALL abandon the wait; the next cycle is in S_RUN with no stall.

Verification
REQ-030 Load-use: i_mem_hazard=1 for one cycle -> o_if_stall=o_id_stall=o_ex_clr=1 for exactly 1 cycle, o_stall_cnt=1, o_lu_err=0.
REQ-031 Branch plus hazard: i_branch_taken=1 and i_mem_hazard=1 together -> o_pc_redirect=o_id_clr=o_ex_clr=1, no stall, o_flush_cnt=1.
REQ-032 Memory wait: i_dmem_req=1, ack after 3 cycles, i_branch_taken=1 throughout -> stalls high for 3 cycles, no redirect until the ack cycle +1, o_stall_cnt=3.
REQ-033 Timeout: MEM_TIMEOUT=4, no ack for 6 cycles -> o_mem_timeout=1 from cycle 5, remains set after the ack, cleared only by clr.
REQ-034 Saturation: CNT_W=3, 10 consecutive stall cycles -> o_stall_cnt=7.
REQ-035 Reset mid-wait: clr pulsed in the 2nd S_MEM_WAIT cycle -> the next cycle has all outputs 0 and all counters 0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a five-stage pipeline: memory-wait FSM, branch flush,
// load-use bubble insertion, sticky error flags and saturating performance counters.
module pipeline_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             i_mem_hazard,
   input  logic             i_branch_taken,
   input  logic             i_dmem_req,
   input  logic             i_dmem_ack,
   output logic             o_if_stall,
   output logic             o_id_stall,
   output logic             o_ex_stall,
   output logic             o_me_stall,
   output logic             o_id_clr,
   output logic             o_ex_clr,
   output logic             o_pc_redirect,
   output logic             o_mem_timeout,
   output logic             o_lu_err,
   output logic [CNT_W-1:0] o_stall_cnt,
   output logic [CNT_W-1:0] o_flush_cnt
);

   localparam logic [0:0] S_RUN      = 1'b0;
   localparam logic [0:0] S_MEM_WAIT = 1'b1;

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   // Handshake: i_dmem_req is a request qualified by i_dmem_ack; the access
   // completes on the first cycle where both are high (possibly the same cycle).

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              lu_prev;

   logic              if_stall;
   logic              id_stall;
   logic              ex_stall;
   logic              me_stall;
   logic              id_clr;
   logic              ex_clr;
   logic              pc_redirect;
   logic              flush_evt;
   logic              lu_stall;
   logic              any_stall;

   always_comb begin
      if_stall    = 1'b0;
      id_stall    = 1'b0;
      ex_stall    = 1'b0;
      me_stall    = 1'b0;
      id_clr      = 1'b0;
      ex_clr      = 1'b0;
      pc_redirect = 1'b0;
      flush_evt   = 1'b0;
      lu_stall    = 1'b0;
      state_nxt   = state;
      if (!clr) begin
         case (state)
            S_RUN: begin
               if (i_dmem_req && !i_dmem_ack) begin
                  if_stall  = 1'b1;
                  id_stall  = 1'b1;
                  ex_stall  = 1'b1;
                  me_stall  = 1'b1;
                  state_nxt = S_MEM_WAIT;
               end else if (i_branch_taken) begin
                  pc_redirect = 1'b1;
                  id_clr      = 1'b1;
                  ex_clr      = 1'b1;
                  flush_evt   = 1'b1;
               end else if (i_mem_hazard) begin
                  // Hold IF/ID, bubble into EX; ME keeps flowing.
                  if_stall = 1'b1;
                  id_stall = 1'b1;
                  ex_clr   = 1'b1;
                  lu_stall = 1'b1;
               end
            end
            S_MEM_WAIT: begin
               // Branch and hazard inputs are held upstream and re-seen in S_RUN.
               if_stall = ~i_dmem_ack;
               id_stall = ~i_dmem_ack;
               ex_stall = ~i_dmem_ack;
               me_stall = ~i_dmem_ack;
               if (i_dmem_ack) state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
         endcase
      end
   end

   assign any_stall = if_stall | id_stall | ex_stall | me_stall;

   always_ff @(posedge clk) begin
      if (clr) begin
         state         <= S_RUN;
         wait_cnt      <= '0;
         lu_prev       <= 1'b0;
         o_mem_timeout <= 1'b0;
         o_lu_err      <= 1'b0;
         o_stall_cnt   <= '0;
         o_flush_cnt   <= '0;
      end else begin
         state   <= state_nxt;
         lu_prev <= lu_stall;

         if (state == S_RUN && state_nxt == S_MEM_WAIT) begin
            wait_cnt <= '0;
         end else if (state == S_MEM_WAIT && wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end

         // Flag rises on the edge where the wait counter reaches MEM_TIMEOUT.
         if (state == S_MEM_WAIT && wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
            o_mem_timeout <= 1'b1;
         end

         if (state == S_RUN && i_mem_hazard && lu_prev) begin
            o_lu_err <= 1'b1;
         end

         if (any_stall && o_stall_cnt != {CNT_W{1'b1}}) begin
            o_stall_cnt <= o_stall_cnt + CNT_W'(1);
         end

         if (flush_evt && o_flush_cnt != {CNT_W{1'b1}}) begin
            o_flush_cnt <= o_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign o_if_stall    = if_stall;
   assign o_id_stall    = id_stall;
   assign o_ex_stall    = ex_stall;
   assign o_me_stall    = me_stall;
   assign o_id_clr      = id_clr;
   assign o_ex_clr      = ex_clr;
   assign o_pc_redirect = pc_redirect;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a default instance and a small one
// (CNT_W=3, MEM_TIMEOUT=4) share the same stimulus.
module tb_pipeline_ctrl;

   logic clk = 1'b0;
   logic clr;
   logic hazard;
   logic branch;
   logic req;
   logic ack;

   int checks   = 0;
   int failures = 0;

   logic        d_if, d_id, d_ex, d_me, d_idc, d_exc, d_red, d_to, d_lu;
   logic [31:0] d_scnt, d_fcnt;
   logic        s_if, s_id, s_ex, s_me, s_idc, s_exc, s_red, s_to, s_lu;
   logic [2:0]  s_scnt, s_fcnt;

   logic [6:0] d_ctrl;
   logic [6:0] s_ctrl;
   assign d_ctrl = {d_if, d_id, d_ex, d_me, d_idc, d_exc, d_red};
   assign s_ctrl = {s_if, s_id, s_ex, s_me, s_idc, s_exc, s_red};

   always #5 clk = ~clk;

   pipeline_ctrl u_dut (
      .clk(clk), .clr(clr), .i_mem_hazard(hazard), .i_branch_taken(branch),
      .i_dmem_req(req), .i_dmem_ack(ack),
      .o_if_stall(d_if), .o_id_stall(d_id), .o_ex_stall(d_ex), .o_me_stall(d_me),
      .o_id_clr(d_idc), .o_ex_clr(d_exc), .o_pc_redirect(d_red),
      .o_mem_timeout(d_to), .o_lu_err(d_lu),
      .o_stall_cnt(d_scnt), .o_flush_cnt(d_fcnt)
   );

   pipeline_ctrl #(.CNT_W(3), .MEM_TIMEOUT(4)) u_small (
      .clk(clk), .clr(clr), .i_mem_hazard(hazard), .i_branch_taken(branch),
      .i_dmem_req(req), .i_dmem_ack(ack),
      .o_if_stall(s_if), .o_id_stall(s_id), .o_ex_stall(s_ex), .o_me_stall(s_me),
      .o_id_clr(s_idc), .o_ex_clr(s_exc), .o_pc_redirect(s_red),
      .o_mem_timeout(s_to), .o_lu_err(s_lu),
      .o_stall_cnt(s_scnt), .o_flush_cnt(s_fcnt)
   );

   // Ctrl vector order: {if_stall, id_stall, ex_stall, me_stall, id_clr, ex_clr, pc_redirect}
   localparam logic [6:0] C_IDLE  = 7'b000_0000;
   localparam logic [6:0] C_LU    = 7'b110_0010;
   localparam logic [6:0] C_BR    = 7'b000_0111;
   localparam logic [6:0] C_STALL = 7'b111_1000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic h, input logic b, input logic r, input logic a);
      hazard = h;
      branch = b;
      req    = r;
      ack    = a;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Outputs are sampled mid-cycle, well away from the edge.
   task automatic chk_ctrl(input string tag, input logic [6:0] exp);
      #2;
      chk({tag, "_ctrl"}, {25'd0, d_ctrl}, {25'd0, exp});
      chk({tag, "_ctrl_small"}, {25'd0, s_ctrl}, {25'd0, exp});
   endtask

   task automatic chk_cnt(input string tag, input int es, input int ef, input int ss, input int sf);
      chk({tag, "_stall_cnt"}, d_scnt, es);
      chk({tag, "_flush_cnt"}, d_fcnt, ef);
      chk({tag, "_stall_cnt_small"}, {29'd0, s_scnt}, ss);
      chk({tag, "_flush_cnt_small"}, {29'd0, s_fcnt}, sf);
   endtask

   initial begin
      // Reset with every input asserted: controls must stay low.
      clr = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      #1;
      chk_ctrl("clr_hold", C_IDLE);
      step();
      chk_ctrl("clr_hold2", C_IDLE);
      step();
      clr = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_ctrl("post_reset", C_IDLE);
      chk_cnt("post_reset", 0, 0, 0, 0);
      chk("post_reset_to", {30'd0, d_to, s_to}, 32'd0);
      chk("post_reset_lu", {30'd0, d_lu, s_lu}, 32'd0);

      // Single-cycle load-use hazard: exactly one bubble.
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk_ctrl("lu_bubble", C_LU);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_ctrl("lu_after", C_IDLE);
      chk_cnt("lu", 1, 0, 1, 0);
      chk("lu_err_single", {31'd0, d_lu}, 32'd0);

      // Branch together with hazard: branch wins, no stall.
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk_ctrl("br_haz", C_BR);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_ctrl("br_after", C_IDLE);
      chk_cnt("br", 1, 1, 1, 1);
      chk("lu_err_br", {30'd0, d_lu, s_lu}, 32'd0);

      // Hazard held two cycles: bubble both cycles, sticky error flagged.
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk_ctrl("lu2_c0", C_LU);
      step();
      chk_ctrl("lu2_c1", C_LU);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_ctrl("lu2_after", C_IDLE);
      chk("lu_err_set", {30'd0, d_lu, s_lu}, 32'd3);
      chk_cnt("lu2", 3, 1, 3, 1);

      // Memory wait with branch held: 3 stall cycles, redirect only after ack cycle.
      step();
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      chk_ctrl("mw_c0", C_STALL);
      step();
      chk_ctrl("mw_c1", C_STALL);
      step();
      chk_ctrl("mw_c2", C_STALL);
      step();
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      chk_ctrl("mw_ack", C_IDLE);
      step();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      chk_ctrl("mw_redirect", C_BR);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("mw", 6, 2, 6, 2);
      chk("mw_no_timeout", {30'd0, d_to, s_to}, 32'd0);

      // Request acknowledged in the same cycle: no stall, stays in S_RUN.
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      chk_ctrl("same_ack", C_IDLE);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      chk_ctrl("same_ack_run", C_LU);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("same_ack", 7, 2, 7, 2);

      // Timeout on the small instance: request with no ack for 6 cycles.
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk_ctrl("to_c0", C_STALL);
      for (int i = 1; i < 5; i++) begin
         step();
      end
      #2;
      chk("to_c4_clear", {31'd0, s_to}, 32'd0);
      step();
      chk_ctrl("to_c5", C_STALL);
      chk("to_c5_set", {31'd0, s_to}, 32'd1);
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      chk_ctrl("to_ack", C_IDLE);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_ctrl("to_idle", C_IDLE);
      chk("to_sticky", {31'd0, s_to}, 32'd1);
      chk("to_default_clear", {31'd0, d_to}, 32'd0);
      chk_cnt("to", 13, 2, 7, 2);

      // Reset pulsed in the second S_MEM_WAIT cycle abandons the wait.
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step();
      step();
      clr = 1'b1;
      chk_ctrl("rst_wait_clr", C_IDLE);
      step();
      clr = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_ctrl("rst_wait_next", C_IDLE);
      chk_cnt("rst_wait", 0, 0, 0, 0);
      chk("rst_wait_flags", {28'd0, d_to, s_to, d_lu, s_lu}, 32'd0);

      // Ten consecutive stall cycles saturate the 3-bit counter at 7.
      step();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step();
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      chk_ctrl("sat_ack", C_IDLE);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk_cnt("sat", 10, 0, 7, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
